register_file_20_4_16x20: RTL and testbench



---
 rtl/register_file_20_4_16x20.sv | 140 ++++++++++++++
 tb/tb_register_file_20_4_16x20.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/register_file_20_4_16x20.sv
`default_nettype none
// ============================================================================
// Module   : register_file_20_4_16x20
// Purpose  : 16-entry x 20-bit register bank. It has one write port, two
//            registered read ports and a sequenced bank-clear sweep.
// Ports    : clk, rst_n (async active-low)
//            wr_valid/wr_ready/wr_addr/wr_data  - write port (valid/ready)
//            rd_{a,b}_en/_addr/_data/_valid     - registered read ports
//            clr_req/busy/clr_done              - bank clear command/status
// Options  : REGFILE_BYPASS_EN - when defined, a same-edge read of an address
//            being written returns the new write data (write-before-read).
//            When undefined, that read returns the old contents.
// Revision : 1.0 - initial release
// ============================================================================
module register_file_20_4_16x20 #(
  parameter int WIDTH  = 20,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_a_en,
  input  logic [ADDR_W-1:0] rd_a_addr,
  output logic [WIDTH-1:0]  rd_a_data,
  output logic              rd_a_valid,
  input  logic              rd_b_en,
  input  logic [ADDR_W-1:0] rd_b_addr,
  output logic [WIDTH-1:0]  rd_b_data,
  output logic              rd_b_valid,
  input  logic              clr_req,
  output logic              busy,
  output logic              clr_done
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                clr_done_q, clr_done_d;
  logic [WIDTH-1:0]    mem_q [DEPTH];
  logic [WIDTH-1:0]    mem_d [DEPTH];
  logic [WIDTH-1:0]    rd_a_data_q, rd_a_data_d;
  logic [WIDTH-1:0]    rd_b_data_q, rd_b_data_d;
  logic                rd_a_valid_q, rd_a_valid_d;
  logic                rd_b_valid_q, rd_b_valid_d;
  logic                wr_accept;

  assign wr_ready   = (state_q == S_IDLE);
  assign busy       = (state_q == S_CLEAR);
  assign clr_done   = clr_done_q;
  assign rd_a_data  = rd_a_data_q;
  assign rd_b_data  = rd_b_data_q;
  assign rd_a_valid = rd_a_valid_q;
  assign rd_b_valid = rd_b_valid_q;
  assign wr_accept  = wr_valid && wr_ready;

  // Sequencer. clr_req has no effect once the sweep has started. The done
  // pulse is registered so that it appears in the cycle after the final
  // entry is zeroed.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    clr_done_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (clr_req) begin
          state_d = S_CLEAR;
          cnt_d   = '0;
        end
      end
      S_CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_IDX) begin
          state_d    = S_IDLE;
          clr_done_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Storage update. Writes are only accepted in IDLE, and the sweep only
  // runs in CLEAR, so the two never target the array on the same edge.
  always_comb begin
    mem_d = mem_q;
    if (state_q == S_CLEAR) begin
      mem_d[cnt_q] = '0;
    end else if (wr_accept) begin
      mem_d[wr_addr] = wr_data;
    end
  end

  // Read ports. The data register holds its value while the port is idle.
  always_comb begin
    rd_a_valid_d = rd_a_en;
    rd_b_valid_d = rd_b_en;
    rd_a_data_d  = rd_a_data_q;
    rd_b_data_d  = rd_b_data_q;
    if (rd_a_en) rd_a_data_d = mem_q[rd_a_addr];
    if (rd_b_en) rd_b_data_d = mem_q[rd_b_addr];
`ifdef REGFILE_BYPASS_EN
    if (rd_a_en && wr_accept && (wr_addr == rd_a_addr)) rd_a_data_d = wr_data;
    if (rd_b_en && wr_accept && (wr_addr == rd_b_addr)) rd_b_data_d = wr_data;
`else
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      clr_done_q   <= 1'b0;
      rd_a_data_q  <= '0;
      rd_b_data_q  <= '0;
      rd_a_valid_q <= 1'b0;
      rd_b_valid_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      clr_done_q   <= clr_done_d;
      rd_a_data_q  <= rd_a_data_d;
      rd_b_data_q  <= rd_b_data_d;
      rd_a_valid_q <= rd_a_valid_d;
      rd_b_valid_q <= rd_b_valid_d;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_register_file_20_4_16x20.sv
`default_nettype none
// ============================================================================
// Module   : tb_register_file_20_4_16x20
// Purpose  : Scoreboard bench for register_file_20_4_16x20. Stimulus pushes
//            expected read data into per-port queues, and a monitor pops and
//            compares them whenever a read port presents valid data.
// Revision : 1.0 - initial release
// ============================================================================
module tb_register_file_20_4_16x20;

  localparam int WIDTH  = 20;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              wr_valid, wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]  wr_data;
  logic              rd_a_en, rd_a_valid, rd_b_en, rd_b_valid;
  logic [ADDR_W-1:0] rd_a_addr, rd_b_addr;
  logic [WIDTH-1:0]  rd_a_data, rd_b_data;
  logic              clr_req, busy, clr_done;

  always #5 clk = ~clk;

  register_file_20_4_16x20 #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_a_en(rd_a_en), .rd_a_addr(rd_a_addr), .rd_a_data(rd_a_data), .rd_a_valid(rd_a_valid),
    .rd_b_en(rd_b_en), .rd_b_addr(rd_b_addr), .rd_b_data(rd_b_data), .rd_b_valid(rd_b_valid),
    .clr_req(clr_req), .busy(busy), .clr_done(clr_done)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: contents array plus a countdown of remaining clear edges.
  logic [WIDTH-1:0] model_mem [DEPTH];
  int               clr_left;
  int               clr_idx;
  bit               model_done;
  logic [WIDTH-1:0] qa [$];
  logic [WIDTH-1:0] qb [$];

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Monitor: each enabled read must appear exactly one edge later.
  always @(negedge clk) begin : mon
    logic [WIDTH-1:0] ea, eb;
    if (rst_n === 1'b1) begin
      chk("rd_a_valid", 32'(rd_a_valid), 32'(qa.size() != 0));
      if (qa.size() != 0) begin
        ea = qa.pop_front();
        if (rd_a_valid) chk("rd_a_data", 32'(rd_a_data), 32'(ea));
      end
      chk("rd_b_valid", 32'(rd_b_valid), 32'(qb.size() != 0));
      if (qb.size() != 0) begin
        eb = qb.pop_front();
        if (rd_b_valid) chk("rd_b_data", 32'(rd_b_data), 32'(eb));
      end
    end
  end

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    clr_left   = 0;
    clr_idx    = 0;
    model_done = 1'b0;
  endtask

  // Check status for the current cycle, predict reads, update the model, and
  // advance one clock. Inputs are driven by the caller before the call.
  task automatic cycle();
    bit busy_e, acc;
    busy_e = (clr_left != 0);
    chk("busy", 32'(busy), 32'(busy_e));
    chk("wr_ready", 32'(wr_ready), 32'(!busy_e));
    chk("clr_done", 32'(clr_done), 32'(model_done));
    acc = wr_valid && !busy_e;
    if (rd_a_en)
      qa.push_back((BYPASS && acc && wr_addr == rd_a_addr) ? wr_data : model_mem[rd_a_addr]);
    if (rd_b_en)
      qb.push_back((BYPASS && acc && wr_addr == rd_b_addr) ? wr_data : model_mem[rd_b_addr]);
    if (busy_e) begin
      model_mem[clr_idx] = '0;
      clr_idx++;
      clr_left--;
      model_done = (clr_left == 0);
    end else begin
      model_done = 1'b0;
      if (acc) model_mem[wr_addr] = wr_data;
      if (clr_req) begin
        clr_left = DEPTH;
        clr_idx  = 0;
      end
    end
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    rd_a_en = 1'b0; rd_a_addr = '0; rd_b_en = 1'b0; rd_b_addr = '0;
    clr_req = 1'b0;
  endtask

  task automatic read_all();
    for (int i = 0; i < DEPTH; i++) begin
      idle_inputs();
      rd_a_en = 1'b1; rd_a_addr = ADDR_W'(i);
      rd_b_en = 1'b1; rd_b_addr = ADDR_W'(DEPTH - 1 - i);
      cycle();
    end
    idle_inputs();
    cycle();
  endtask

  task automatic rand_reads();
    rd_a_en = 1'($urandom_range(1, 0)); rd_a_addr = ADDR_W'($urandom_range(DEPTH - 1, 0));
    rd_b_en = 1'($urandom_range(1, 0)); rd_b_addr = ADDR_W'($urandom_range(DEPTH - 1, 0));
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_wr_ready", 32'(wr_ready), 32'd1);
    chk("rst_clr_done", 32'(clr_done), 32'd0);
    chk("rst_rd_a_valid", 32'(rd_a_valid), 32'd0);
    chk("rst_rd_b_valid", 32'(rd_b_valid), 32'd0);
    chk("rst_rd_a_data", 32'(rd_a_data), 32'd0);
    chk("rst_rd_b_data", 32'(rd_b_data), 32'd0);
    @(posedge clk);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b1;
    model_reset();
    #2;
    apply_reset();

    // Reset contents: every entry reads zero on both ports.
    read_all();

    // Back-to-back writes followed by a dual read.
    idle_inputs(); wr_valid = 1'b1; wr_addr = 4'd5;  wr_data = 20'hABCDE; cycle();
    idle_inputs(); wr_valid = 1'b1; wr_addr = 4'd15; wr_data = 20'h12345; cycle();
    idle_inputs(); rd_a_en = 1'b1; rd_a_addr = 4'd5; rd_b_en = 1'b1; rd_b_addr = 4'd15; cycle();

    // Same-cycle write and read of one address.
    idle_inputs(); wr_valid = 1'b1; wr_addr = 4'd3; wr_data = 20'hFFFFF;
    rd_a_en = 1'b1; rd_a_addr = 4'd3; cycle();
    idle_inputs(); rd_a_en = 1'b1; rd_a_addr = 4'd3; cycle();

    // Fill, then clear while a write to entry 7 is held pending.
    for (int i = 0; i < DEPTH; i++) begin
      idle_inputs(); wr_valid = 1'b1; wr_addr = ADDR_W'(i); wr_data = 20'h10000 + 20'(i); cycle();
    end
    idle_inputs(); wr_valid = 1'b1; wr_addr = 4'd7; wr_data = 20'h00777; clr_req = 1'b1; cycle();
    for (int c = 0; c < 17; c++) begin
      clr_req = 1'b0; rand_reads(); cycle();
    end
    idle_inputs(); cycle();
    read_all();

    // Second clr_req four cycles into a sweep must be ignored.
    idle_inputs(); clr_req = 1'b1; cycle();
    idle_inputs();
    for (int c = 0; c < 4; c++) cycle();
    clr_req = 1'b1; cycle();
    idle_inputs();
    for (int c = 0; c < 14; c++) begin rand_reads(); cycle(); end
    idle_inputs(); cycle();

    // Reset in the middle of a sweep.
    for (int i = 0; i < DEPTH; i++) begin
      idle_inputs(); wr_valid = 1'b1; wr_addr = ADDR_W'(i); wr_data = 20'($urandom()); cycle();
    end
    idle_inputs(); clr_req = 1'b1; cycle();
    idle_inputs();
    for (int c = 0; c < 6; c++) cycle();
    apply_reset();
    idle_inputs();
    for (int c = 0; c < 3; c++) cycle();
    read_all();

    // Randomized traffic with occasional clears.
    for (int c = 0; c < 400; c++) begin
      idle_inputs();
      wr_valid = 1'($urandom_range(1, 0));
      wr_addr  = ADDR_W'($urandom_range(DEPTH - 1, 0));
      wr_data  = 20'($urandom());
      rand_reads();
      clr_req  = ($urandom_range(29, 0) == 0);
      cycle();
    end
    idle_inputs();
    for (int c = 0; c < 18; c++) cycle();
    read_all();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
